// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and AXI constants for the SRAM-to-AXI bridge.
// State encoding, burst/size/response codes and the wen-to-size mapping.
// No logic of its own; imported by the bridge.
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_B     = 3'd0;
    localparam logic [2:0] SIZE_H     = 3'd1;
    localparam logic [2:0] SIZE_W     = 3'd2;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Full word and irregular strobe patterns go out as word-sized beats.
    function automatic logic [2:0] size_from_wen(input logic [3:0] wen);
        logic [2:0] size;
        case (wen)
            4'b1111:                            size = SIZE_W;
            4'b0011, 4'b1100:                   size = SIZE_H;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
            default:                            size = SIZE_W;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// SRAM-style core data port to single-outstanding AXI master; stallreq held while a transaction is in flight.
// Latency: request cycle + address/data handshakes + response, then one DONE cycle with stall low and data valid.
// Backpressure: every AXI valid is held until its ready; optional BRIDGE_POSTED_WRITE_EN finishes writes before B returns.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            sram_en,
    input  logic [3:0]      sram_wen,
    input  logic [31:0]     sram_addr,
    input  logic [31:0]     sram_wdata,
    output logic [31:0]     sram_rdata,
    output logic            stallreq,
    output logic            bus_err,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wen_q;
    logic        aw_done;
    logic        w_done;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        issue;
    logic        wr_last;

    // Only one transaction is ever outstanding, so response IDs and rlast carry no information.
    logic unused_sig;
    assign unused_sig = ^{rid, rlast, bid};

    // Both write channels are finished this cycle (already done, or handshaking now).
    assign wr_last = (state == ST_WR) && (aw_done || awready) && (w_done || wready);

`ifdef BRIDGE_POSTED_WRITE_EN
    logic b_pending;

    // A pending B blocks a new request, unless it returns in the same cycle.
    assign issue  = sram_en && (!b_pending || bvalid);
    assign bready = b_pending;

    // Track the one posted write whose response has not yet arrived.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            b_pending <= 1'b0;
        end else if (wr_last) begin
            b_pending <= 1'b1;
        end else if (bvalid) begin
            b_pending <= 1'b0;
        end
    end
`else
    assign issue  = sram_en;
    assign bready = (state == ST_WR_RESP);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state channel strobes.
    always_comb begin
        state_nxt = state;
        stallreq  = 1'b1;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        case (state)
            ST_IDLE: begin
                stallreq = sram_en;
                if (issue) begin
                    state_nxt = (sram_wen == 4'b0000) ? ST_RD_ADDR : ST_WR;
                end
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_nxt = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WR: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if (wr_last) begin
`ifdef BRIDGE_POSTED_WRITE_EN
                    state_nxt = ST_DONE;
`else
                    state_nxt = ST_WR_RESP;
`endif
                end
            end
            ST_WR_RESP: begin
                if (bvalid) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                stallreq  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, write-channel progress flags, read data and sticky error.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wen_q   <= 4'h0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && issue) begin
                addr_q  <= sram_addr;
                wdata_q <= sram_wdata;
                wen_q   <= sram_wen;
            end
            if (state == ST_WR) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (rvalid && rready) begin
                rdata_q <= rdata;
                if (rresp != RESP_OKAY) err_q <= 1'b1;
            end
            if (bvalid && bready && bresp != RESP_OKAY) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sram_rdata = rdata_q;
    assign bus_err    = err_q;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = SIZE_W;
    assign arburst = BURST_INCR;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = size_from_wen(wen_q);
    assign awburst = BURST_INCR;

    assign wdata   = wdata_q;
    assign wstrb   = wen_q;
    assign wlast   = wvalid;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: table of core requests against a delay-configurable AXI slave.
// Expected AXI beats are queued when a request is driven and popped on each handshake.
// Stall length, returned data and the sticky error flag are checked in the DONE cycle.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic        stallreq, bus_err;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, rresp, awburst, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    sram_axi_bridge #(.ID_W(4), .AXI_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .stallreq(stallreq), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected handshake, value 0x%0h", name, act);
    endtask

    // Slave configuration for the current request.
    int          a_dly, w_dly, rsp_dly;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_resp;
    // Slave state.
    int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt, r_lim, b_lim;
    bit          r_pend, b_pend, aw_got, w_got;
    logic [31:0] r_word;
    logic [1:0]  r_rsp, b_rsp;
    // Reference model.
    bit          err_pipe, err_vis;
    logic [31:0] last_rd;
    bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr;
    logic [31:0] exp_ar[$];
    logic [34:0] exp_aw[$];
    logic [35:0] exp_w[$];

    task automatic clear_model();
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        err_pipe = 0; err_vis = 0; last_rd = 32'h0;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    endtask

    // AXI slave: observe at negedge, drive responses just after posedge.
    always begin
        logic [34:0] eaw;
        logic [35:0] ew;
        @(negedge clk);
        if (resetn) begin
            err_vis = err_pipe;
            if (p_arv && !p_arr) chk("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, p_araddr}));
            if (p_awv && !p_awr) chk("aw_hold", 64'(awvalid), 64'd1);
            if (p_wv && !p_wr)   chk("w_hold", 64'(wvalid), 64'd1);
            if (arvalid && !arready) ar_cnt++;
            if (awvalid && !awready) aw_cnt++;
            if (wvalid && !wready)   w_cnt++;
            if (r_pend && !(rvalid && rready)) r_cnt++;
            if (b_pend && !(bvalid && bready)) b_cnt++;
            if (rvalid && rready) begin
                r_pend = 0;
                err_pipe = err_pipe | (r_rsp != 2'b00);
            end
            if (bvalid && bready) begin
                b_pend = 0;
                err_pipe = err_pipe | (b_rsp != 2'b00);
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) miss("ar_unexpected", 64'(araddr));
                else chk("ar_beat", 64'({arid, araddr, arlen, arsize, arburst}),
                         64'({4'd1, exp_ar.pop_front(), 8'd0, 3'd2, 2'b01}));
                ar_cnt = 0; r_pend = 1; r_cnt = 0; r_lim = rsp_dly;
                r_word = cfg_rdata; r_rsp = cfg_resp;
            end
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) miss("aw_unexpected", 64'(awaddr));
                else begin
                    eaw = exp_aw.pop_front();
                    chk("aw_beat", 64'({awid, awaddr, awlen, awsize, awburst}),
                        64'({4'd1, eaw[34:3], 8'd0, eaw[2:0], 2'b01}));
                end
                aw_cnt = 0; aw_got = 1;
            end
            if (wvalid && wready) begin
                if (exp_w.size() == 0) miss("w_unexpected", 64'(wdata));
                else begin
                    ew = exp_w.pop_front();
                    chk("w_beat", 64'({wdata, wstrb, wlast}), 64'({ew, 1'b1}));
                end
                w_cnt = 0; w_got = 1;
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                b_lim = rsp_dly; b_rsp = cfg_resp;
            end
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
        end
        @(posedge clk);
        #1;
        arready = arvalid && (ar_cnt >= a_dly);
        awready = awvalid && (aw_cnt >= a_dly);
        wready  = wvalid && (w_cnt >= w_dly);
        rvalid  = r_pend && (r_cnt >= r_lim);
        rdata   = rvalid ? r_word : 32'h0;
        rresp   = rvalid ? r_rsp : 2'b00;
        rlast   = rvalid;
        rid     = 4'd1;
        bvalid  = b_pend && (b_cnt >= b_lim);
        bresp   = bvalid ? b_rsp : 2'b00;
        bid     = 4'd1;
    end

    // One core request: hold it until the stall drops, then check the DONE cycle.
    task automatic do_req(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] size, input logic [1:0] resp,
                          input int ad, input int wd, input int rd, input int exp_stall);
        int stalls = 0;
        bit done = 0;
        @(posedge clk);
        #1;
        a_dly = ad; w_dly = wd; rsp_dly = rd; cfg_rdata = data; cfg_resp = resp;
        sram_en = 1'b1; sram_wen = wen; sram_addr = addr; sram_wdata = data;
        if (wen == 4'b0000) exp_ar.push_back(addr);
        else begin
            exp_aw.push_back({addr, size});
            exp_w.push_back({data, wen});
        end
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #1;
            if (stallreq) begin
                stalls++;
                @(posedge clk);
                #1;
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: stallreq still high after 200 cycles", tag);
        end
        if (wen == 4'b0000) last_rd = data;
        chk({tag, "_stall"}, 64'(stalls), 64'(exp_stall));
        chk({tag, "_rdata"}, 64'(sram_rdata), 64'(last_rd));
        chk({tag, "_err"}, 64'(bus_err), 64'(err_vis));
        chk({tag, "_pending"}, 64'(exp_ar.size() + exp_aw.size() + exp_w.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sram_en = 1'b0;
            @(negedge clk);
            #1;
            chk("idle_stall", 64'(stallreq), 64'd0);
            chk("idle_rdata", 64'(sram_rdata), 64'(last_rd));
        end
    endtask

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        int          ad, wd, rd;
        int          stall_np, stall_p;
    } vec_t;

    vec_t tbl[8];
    int   exp_s;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0000, 32'h0000_1000, 32'hDEAD_BEEF, 3'd2, 0, 0, 0, 3, 3};
        tbl[1] = '{4'b1111, 32'h0000_2004, 32'h1234_5678, 3'd2, 0, 2, 1, 6, 4};
        tbl[2] = '{4'b0100, 32'h0000_3002, 32'h00AA_0000, 3'd0, 1, 0, 0, 4, 3};
        tbl[3] = '{4'b1100, 32'h0000_3000, 32'hBEEF_0000, 3'd1, 0, 0, 0, 3, 2};
        tbl[4] = '{4'b0011, 32'h0000_3010, 32'h0000_CAFE, 3'd1, 2, 2, 2, 7, 4};
        tbl[5] = '{4'b0101, 32'h0000_3020, 32'h0011_0022, 3'd2, 0, 1, 0, 4, 4};
        tbl[6] = '{4'b0000, 32'h0000_1004, 32'h0BAD_F00D, 3'd2, 2, 0, 3, 8, 8};
        tbl[7] = '{4'b1000, 32'h0000_3033, 32'h7700_0000, 3'd0, 3, 0, 0, 6, 5};

        resetn = 1'b0; sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = 32'h0; rresp = 2'b00; rlast = 0; rid = 4'd1; bresp = 2'b00; bid = 4'd1;
        a_dly = 0; w_dly = 0; rsp_dly = 0; cfg_rdata = 32'h0; cfg_resp = 2'b00;
        clear_model();

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        chk("rst_rdata", 64'(sram_rdata), 64'd0);
        chk("rst_err", 64'(bus_err), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Back-to-back requests; sram_en stays high through every DONE cycle.
        for (int i = 0; i < 8; i++) begin
`ifdef BRIDGE_POSTED_WRITE_EN
            exp_s = tbl[i].stall_p;
`else
            exp_s = tbl[i].stall_np;
`endif
            do_req($sformatf("vec%0d", i), tbl[i].wen, tbl[i].addr, tbl[i].data, tbl[i].size,
                   2'b00, tbl[i].ad, tbl[i].wd, tbl[i].rd, exp_s);
        end
        idle(2);

        // Error response is sticky across later OKAY transactions.
        do_req("err_rd", 4'b0000, 32'h0000_1010, 32'h55AA_55AA, 3'd2, 2'b10, 0, 0, 0, 3);
`ifdef BRIDGE_POSTED_WRITE_EN
        exp_s = 2;
`else
        exp_s = 3;
`endif
        do_req("ok_wr", 4'b1111, 32'h0000_2010, 32'h0F0F_0F0F, 3'd2, 2'b00, 0, 0, 0, exp_s);
        do_req("ok_rd", 4'b0000, 32'h0000_1014, 32'h2468_ACE0, 3'd2, 2'b00, 0, 0, 0, 3);
        idle(1);
        chk("err_sticky", 64'(bus_err), 64'd1);

        // Reset while waiting in RD_DATA abandons the read.
        @(posedge clk);
        #1;
        a_dly = 0; rsp_dly = 10; cfg_rdata = 32'hFFFF_0000; cfg_resp = 2'b00;
        sram_en = 1'b1; sram_wen = 4'b0000; sram_addr = 32'h0000_1008;
        exp_ar.push_back(32'h0000_1008);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        chk("mid_rready", 64'(rready), 64'd1);
        resetn = 1'b0;
        sram_en = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("rst2_valids", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
        chk("rst2_stall", 64'(stallreq), 64'd0);
        chk("rst2_rdata", 64'(sram_rdata), 64'd0);
        chk("rst2_err", 64'(bus_err), 64'd0);
        do_req("post_rst_rd", 4'b0000, 32'h0000_1020, 32'h600D_CAFE, 3'd2, 2'b00, 0, 0, 0, 3);

        // Write with a slow B followed immediately by a read.
`ifdef BRIDGE_POSTED_WRITE_EN
        exp_s = 2;
`else
        exp_s = 7;
`endif
        do_req("slowb_wr", 4'b1111, 32'h0000_4000, 32'hA5A5_A5A5, 3'd2, 2'b00, 0, 0, 4, exp_s);
`ifdef BRIDGE_POSTED_WRITE_EN
        exp_s = 6;
`else
        exp_s = 3;
`endif
        do_req("slowb_rd", 4'b0000, 32'h0000_1030, 32'h1357_9BDF, 3'd2, 2'b00, 0, 0, 0, exp_s);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
